// File: rtl/mac_cluster_seq_if.sv
// mac_cluster_seq_if: job control, memory fetch and result-stream bundle for mac_cluster_seq.
interface mac_cluster_seq_if #(
  parameter int W      = 8,
  parameter int ACC_W  = 24,
  parameter int N_MACS = 4,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  localparam int IW    = N_MACS > 1 ? $clog2(N_MACS) : 1
);
  logic                    start;
  logic [LEN_W-1:0]        k_len;
  logic [ADDR_W-1:0]       w_base;
  logic [ADDR_W-1:0]       a_base;
  logic                    w_rd_en;
  logic [ADDR_W-1:0]       w_addr;
  logic [N_MACS*W-1:0]     w_rd_data;
  logic                    a_rd_en;
  logic [ADDR_W-1:0]       a_addr;
  logic [W-1:0]            a_rd_data;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [ACC_W-1:0] res_data;
  logic [IW-1:0]           res_idx;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic                    sat_flag;
  modport master (
    output start, k_len, w_base, a_base, w_rd_data, a_rd_data, res_ready,
    input  w_rd_en, w_addr, a_rd_en, a_addr, res_valid, res_data, res_idx, busy, done, err, sat_flag
  );
  modport slave (
    input  start, k_len, w_base, a_base, w_rd_data, a_rd_data, res_ready,
    output w_rd_en, w_addr, a_rd_en, a_addr, res_valid, res_data, res_idx, busy, done, err, sat_flag
  );
endinterface

// File: rtl/mac_cluster_seq.sv
// mac_cluster_seq: sequenced N-lane dot-product job with memory fetch and streamed results.
// Define MAC_SAT_EN for saturating accumulation with sticky sat_flag; otherwise accumulators wrap.
module mac_cluster_seq #(
  parameter int W      = 8,
  parameter int ACC_W  = 24,
  parameter int N_MACS = 4,
  parameter int K_MAX  = 16,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input logic clk,
  input logic rst,
  mac_cluster_seq_if.slave bus
);
  localparam int IW = N_MACS > 1 ? $clog2(N_MACS) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, FLUSH, OUT, DONE} state_t;
  state_t state, state_nxt;
  logic [LEN_W-1:0] len, cnt;
  logic [ADDR_W-1:0] w_base, a_base;
  logic [IW-1:0] idx;
  logic rd_vld, err_q, sat_q, ok, last_k, last_idx, hs;
  logic signed [ACC_W-1:0] acc [N_MACS];
  logic signed [ACC_W-1:0] acc_nxt [N_MACS];
  logic [N_MACS-1:0] clamp;
  assign ok = bus.start && bus.k_len != '0 && bus.k_len <= LEN_W'(K_MAX);
  assign last_k = cnt == len - 1'b1;
  assign last_idx = idx == IW'(N_MACS - 1);
  assign hs = bus.res_valid && bus.res_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = ok ? FETCH : IDLE;
      FETCH:   state_nxt = last_k ? FLUSH : FETCH;
      FLUSH:   state_nxt = OUT;
      OUT:     state_nxt = hs && last_idx ? DONE : OUT;
      default: state_nxt = IDLE;
    endcase
  end
  // Read data returns one cycle after the strobe, so rd_vld marks the accumulate cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      len <= '0;
      cnt <= '0;
      w_base <= '0;
      a_base <= '0;
      idx <= '0;
      rd_vld <= 1'b0;
      err_q <= 1'b0;
      sat_q <= 1'b0;
      for (int i = 0; i < N_MACS; i++) acc[i] <= '0;
    end else begin
      rd_vld <= bus.w_rd_en;
      err_q <= state == IDLE && bus.start && !ok;
      if (state == IDLE && ok) begin
        len <= bus.k_len;
        w_base <= bus.w_base;
        a_base <= bus.a_base;
        cnt <= '0;
        idx <= '0;
        sat_q <= 1'b0;
        for (int i = 0; i < N_MACS; i++) acc[i] <= '0;
      end else begin
        if (state == FETCH) cnt <= cnt + 1'b1;
        if (hs) idx <= idx + 1'b1;
        if (rd_vld) begin
          for (int i = 0; i < N_MACS; i++) acc[i] <= acc_nxt[i];
          sat_q <= sat_q | (|clamp);
        end
      end
    end
  for (genvar i = 0; i < N_MACS; i++) begin : g_lane
    logic signed [2*W-1:0] prod;
    assign prod = (2*W)'($signed(bus.a_rd_data)) * (2*W)'($signed(bus.w_rd_data[i*W +: W]));
`ifdef MAC_SAT_EN
    logic signed [ACC_W:0] sum;
    assign sum = (ACC_W+1)'(acc[i]) + (ACC_W+1)'(prod);
    assign clamp[i] = sum[ACC_W] != sum[ACC_W-1];
    assign acc_nxt[i] = !clamp[i] ? sum[ACC_W-1:0] :
                        sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign clamp[i] = 1'b0;
    assign acc_nxt[i] = acc[i] + ACC_W'(prod);
`endif
  end
  assign bus.w_rd_en = state == FETCH;
  assign bus.a_rd_en = state == FETCH;
  assign bus.w_addr = w_base + ADDR_W'(cnt);
  assign bus.a_addr = a_base + ADDR_W'(cnt);
  assign bus.res_valid = state == OUT;
  assign bus.res_data = bus.res_valid ? acc[idx] : '0;
  assign bus.res_idx = bus.res_valid ? idx : '0;
  assign bus.busy = state == FETCH || state == FLUSH || state == OUT;
  assign bus.done = state == DONE;
  assign bus.err = err_q;
  assign bus.sat_flag = sat_q;
endmodule

// File: doc/mac_cluster_seq.md
# mac_cluster_seq

Parametrised successor to the fixed 4-lane MAC system top. It merges sequencing, memory fetch and accumulation into one block. A single `start` runs a complete dot-product job: `k_len` activation/weight-vector pairs are fetched from two external synchronous memories and accumulated into `N_MACS` lanes. Results then stream out one lane at a time over a valid/ready port. It sits between the weight/input memories and the downstream result consumer and replaces the separate top/valid/weight pipeline controllers.

## Interface
- `W`, 8: signed activation and weight width
- `ACC_W`, 24: signed accumulator and result width (must be ≥ 2*W)
- `N_MACS`, 4: lane count (≥ 1)
- `K_MAX`, 16: largest legal `k_len`
- `ADDR_W`, 8: memory address width
- `LEN_W`, 8: width of `k_len`

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  job request, sampled only in IDLE
- `k_len`  in  LEN_W  vector length, sampled with `start`
- `w_base`  in  ADDR_W  weight start address, sampled with `start`
- `a_base`  in  ADDR_W  activation start address, sampled with `start`
- `w_rd_en`  out  1  weight memory read strobe
- `w_addr`  out  ADDR_W  weight address
- `w_rd_data`  in  N_MACS*W  packed weights; lane i is bits [i*W +: W]
- `a_rd_en`  out  1  activation memory read strobe
- `a_addr`  out  ADDR_W  activation address
- `a_rd_data`  in  W  activation
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts
- `res_data`  out  ACC_W  lane result, signed
- `res_idx`  out  max(1,$clog2(N_MACS))  lane index of `res_data`
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle pulse at job end
- `err`  out  1  one-cycle pulse on rejected start
- `sat_flag`  out  1  sticky per job; set if any lane saturated

## Operation
- State machine: IDLE → FETCH → FLUSH → OUT → DONE → IDLE.
- IDLE: on `start`, latch `k_len`/`w_base`/`a_base`, clear all accumulators and `sat_flag`, go to FETCH.
  - If `k_len`==0 or `k_len`>`K_MAX`: pulse `err`, no reads, stay IDLE.
- FETCH: assert both read strobes for exactly `k_len` cycles. Addresses are base+k for k=0..k_len-1 and wrap modulo 2^ADDR_W.
- Memories have a fixed 1-cycle read latency. Data for a read issued in cycle t is consumed in cycle t+1. Every lane i computes acc_i += a*w_i, with the product a full 2W signed value sign-extended to ACC_W.
- FLUSH: one cycle to consume the final read.
- OUT: present lanes 0..N_MACS-1 in order. `res_idx` advances on each `res_valid && res_ready` handshake.
  - `res_data`/`res_idx` stay stable while `res_valid` && !`res_ready`.
- DONE: pulse `done` for one cycle, return to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `busy` = state ∈ {FETCH, FLUSH, OUT}.
- Accumulators hold their values after the job until the next accepted `start`.

## Timing
- Reset values: all outputs 0. Accumulators are 0 and state is IDLE.
- `start` accepted in cycle 0. Reads are issued in cycles 1..k_len and `busy` rises in cycle 1.
- Final accumulator values are visible in cycle k_len+2, which is also the first cycle of `res_valid` (idx 0).
- With `res_ready` held high, one result per cycle: cycles k_len+2 .. k_len+1+N_MACS.
- `done` pulses the cycle after the last handshake. `busy` is low in that cycle, and the next `start` is accepted in the cycle after `done`.
- `err` pulses in cycle 1 for a rejected `start`.
- `rst` low at any time: immediate return to IDLE with all outputs 0. No `done` is produced for the aborted job.
- Read strobes are never asserted outside FETCH.

## Configuration
- `MAC_SAT_EN` defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and `sat_flag` is set sticky when any clamp occurs.
- `MAC_SAT_EN` undefined: accumulation wraps modulo 2^ACC_W, and `sat_flag` is tied to 0.

## Test plan
- Basic: N_MACS=4, k_len=3, activations 1,2,3, every weight of lane i = i+1, `res_ready`=1.
  - Results 6,12,18,24 with idx 0..3 in cycles 5..8.
  - `done` in cycle 9; `busy` high in cycles 1..8.
- Backpressure: same job with `res_ready`=0 for 3 cycles while idx 0 is valid.
  - `res_data`=6 and `res_idx`=0 stay stable; `done` is delayed by 3 cycles.
- Saturation (ACC_W=16, MAC_SAT_EN): k_len=16, a=127, all w=127.
  - All lanes 32767 and `sat_flag`=1.
  - With a=-128 instead: all lanes -32768.
  - Without the macro: lanes equal 258064 mod 2^16 as signed (-4080) and `sat_flag`=0.
- Illegal length and ignored start:
  - k_len=0, then k_len=17 (K_MAX=16): `err` pulse in cycle 1 each time; no read strobes; `busy` stays 0.
  - `start` during FETCH is ignored.
- Address wrap: w_base=0xFE, a_base=0xFF, k_len=3.
  - w_addr sequence FE,FF,00; a_addr sequence FF,00,01.
- Reset mid-job: `rst` low in cycle 3 of a k_len=8 job.
  - All outputs 0 immediately; no `done`.
  - A new `start` after release completes correctly.
